// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// the default register-index width and the x0 index.
package hazard_pkg;

  typedef enum logic [1:0] {
    S_RUN        = 2'd0,
    S_LOAD_STALL = 2'd1,
    S_MEM_WAIT   = 2'd2
  } state_t;

  localparam int REG_ADDR_W_DEF = 5;
  localparam int X0_IDX         = 0;

endpackage

// File: rtl/hazard_perf_counters.sv
// Wrap-around event counters for load-use bubbles, memory-freeze cycles and
// branch flushes. Instantiated only when HAZARD_PERF_CNT_EN is defined.
module hazard_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_stall,
  input  logic             i_freeze,
  input  logic             i_flush,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_freeze_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_freeze_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt  <= '0;
      r_freeze_cnt <= '0;
      r_flush_cnt  <= '0;
    end else begin
      if (i_stall)  r_stall_cnt  <= r_stall_cnt  + CNT_W'(1);
      if (i_freeze) r_freeze_cnt <= r_freeze_cnt + CNT_W'(1);
      if (i_flush)  r_flush_cnt  <= r_flush_cnt  + CNT_W'(1);
    end
  end

  assign o_stall_cnt  = r_stall_cnt;
  assign o_freeze_cnt = r_freeze_cnt;
  assign o_flush_cnt  = r_flush_cnt;

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush controller for the 5-stage RV32I pipeline: load-use bubble,
// data-memory freeze with timeout, branch flush. HAZARD_PERF_CNT_EN adds counters.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
  parameter int MEM_TIMEOUT = 64
`ifdef HAZARD_PERF_CNT_EN
  ,
  parameter int CNT_W       = 32
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] IF_ID_RS1,
  input  logic [REG_ADDR_W-1:0] IF_ID_RS2,
  input  logic                  IF_ID_UsesRS2,
  input  logic [REG_ADDR_W-1:0] ID_EX_RD,
  input  logic                  ID_EX_MemRead,
  input  logic                  BRANCH_TAKEN,
  input  logic                  DMEM_REQ,
  input  logic                  DMEM_READY,
  output logic                  PCWrite,
  output logic                  IF_ID_Write,
  output logic                  IF_ID_Flush,
  output logic                  ID_EX_Write,
  output logic                  ID_EX_Flush,
  output logic                  EX_MEM_Write,
  output logic                  MEM_WB_Write,
  output logic                  MEM_ERR
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      STALL_CNT,
  output logic [CNT_W-1:0]      FREEZE_CNT,
  output logic [CNT_W-1:0]      FLUSH_CNT
`endif
);

  localparam int              WAIT_W    = $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic                r_mem_err;
  logic                w_freeze;
  logic                w_rd_nz;
  logic                w_lu;
  logic                w_lu_act;

  assign w_freeze = DMEM_REQ & ~DMEM_READY;
  assign w_rd_nz  = (ID_EX_RD != REG_ADDR_W'(X0_IDX));
  assign w_lu     = ID_EX_MemRead & w_rd_nz &
                    ((ID_EX_RD == IF_ID_RS1) | (IF_ID_UsesRS2 & (ID_EX_RD == IF_ID_RS2)));
  // One bubble per load: the cycle after a bubble never re-stalls.
  assign w_lu_act = w_lu & (r_state != S_LOAD_STALL);

  always_comb begin
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Write  = 1'b1;
    ID_EX_Flush  = 1'b0;
    EX_MEM_Write = 1'b1;
    MEM_WB_Write = 1'b1;
    w_state_nxt  = S_RUN;
    if (reset) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Write  = 1'b0;
      EX_MEM_Write = 1'b0;
      MEM_WB_Write = 1'b0;
      IF_ID_Flush  = 1'b1;
      ID_EX_Flush  = 1'b1;
    end else if (w_freeze) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Write  = 1'b0;
      EX_MEM_Write = 1'b0;
      MEM_WB_Write = 1'b0;
      w_state_nxt  = S_MEM_WAIT;
    end else if (BRANCH_TAKEN) begin
      IF_ID_Flush  = 1'b1;
      ID_EX_Flush  = 1'b1;
    end else if (w_lu_act) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Flush  = 1'b1;
      w_state_nxt  = S_LOAD_STALL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_RUN;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_freeze) begin
        if (r_wait_cnt != WAIT_LAST) r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
        if (r_wait_cnt == WAIT_LAST) r_mem_err  <= 1'b1;
      end else begin
        r_wait_cnt <= '0;
      end
    end
  end

  assign MEM_ERR = r_mem_err;

`ifdef HAZARD_PERF_CNT_EN
  logic w_cnt_stall;
  logic w_cnt_freeze;
  logic w_cnt_flush;

  assign w_cnt_freeze = ~reset & w_freeze;
  assign w_cnt_flush  = ~reset & ~w_freeze & BRANCH_TAKEN;
  assign w_cnt_stall  = ~reset & ~w_freeze & ~BRANCH_TAKEN & w_lu_act;

  hazard_perf_counters #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk         (clk),
    .reset       (reset),
    .i_stall     (w_cnt_stall),
    .i_freeze    (w_cnt_freeze),
    .i_flush     (w_cnt_flush),
    .o_stall_cnt (STALL_CNT),
    .o_freeze_cnt(FREEZE_CNT),
    .o_flush_cnt (FLUSH_CNT)
  );
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit (MEM_TIMEOUT = 4); counter checks
// are compiled in when HAZARD_PERF_CNT_EN is defined.
module tb_hazard_control_unit;

  // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_MEM_Write, MEM_WB_Write}
  localparam logic [6:0] O_DEF   = 7'b1101011;
  localparam logic [6:0] O_RST   = 7'b0010100;
  localparam logic [6:0] O_STALL = 7'b0001111;
  localparam logic [6:0] O_BR    = 7'b1111111;
  localparam logic [6:0] O_FRZ   = 7'b0000000;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] IF_ID_RS1, IF_ID_RS2, ID_EX_RD;
  logic       IF_ID_UsesRS2, ID_EX_MemRead, BRANCH_TAKEN, DMEM_REQ, DMEM_READY;
  logic       PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush;
  logic       EX_MEM_Write, MEM_WB_Write, MEM_ERR;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] STALL_CNT, FREEZE_CNT, FLUSH_CNT;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_control_unit #(
    .REG_ADDR_W (5),
    .MEM_TIMEOUT(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .IF_ID_RS1    (IF_ID_RS1),
    .IF_ID_RS2    (IF_ID_RS2),
    .IF_ID_UsesRS2(IF_ID_UsesRS2),
    .ID_EX_RD     (ID_EX_RD),
    .ID_EX_MemRead(ID_EX_MemRead),
    .BRANCH_TAKEN (BRANCH_TAKEN),
    .DMEM_REQ     (DMEM_REQ),
    .DMEM_READY   (DMEM_READY),
    .PCWrite      (PCWrite),
    .IF_ID_Write  (IF_ID_Write),
    .IF_ID_Flush  (IF_ID_Flush),
    .ID_EX_Write  (ID_EX_Write),
    .ID_EX_Flush  (ID_EX_Flush),
    .EX_MEM_Write (EX_MEM_Write),
    .MEM_WB_Write (MEM_WB_Write),
    .MEM_ERR      (MEM_ERR)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .STALL_CNT    (STALL_CNT),
    .FREEZE_CNT   (FREEZE_CNT),
    .FLUSH_CNT    (FLUSH_CNT)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    IF_ID_RS1     = 5'd0;
    IF_ID_RS2     = 5'd0;
    IF_ID_UsesRS2 = 1'b0;
    ID_EX_RD      = 5'd0;
    ID_EX_MemRead = 1'b0;
    BRANCH_TAKEN  = 1'b0;
    DMEM_REQ      = 1'b0;
    DMEM_READY    = 1'b1;
  endtask

  task automatic load_use(input logic [4:0] rd, input logic [4:0] rs1);
    ID_EX_MemRead = 1'b1;
    ID_EX_RD      = rd;
    IF_ID_RS1     = rs1;
  endtask

  task automatic chk_out(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    obs = {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_MEM_Write, MEM_WB_Write};
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: controls got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic chk_err(input string tag, input logic exp);
    n_checks++;
    assert (MEM_ERR === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: MEM_ERR got %b want %b", tag, MEM_ERR, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: count got %0d want %0d", tag, obs, exp);
    end
  endtask

  initial begin
    idle();
    reset = 1'b1;
    settle();
    chk_out("reset_comb", O_RST);
    tick();
    chk_out("reset_held", O_RST);
    chk_err("reset_err", 1'b0);
    reset = 1'b0;
    settle();
    chk_out("default", O_DEF);
    tick();

    // load-use on rs1: one bubble, then defaults with inputs held
    load_use(5'd5, 5'd5);
    settle();
    chk_out("lu_rs1", O_STALL);
    tick();
    chk_out("lu_rs1_once", O_DEF);
    tick();
    idle();

    // rs2 dependency honoured only when UsesRS2
    ID_EX_MemRead = 1'b1; ID_EX_RD = 5'd7; IF_ID_RS2 = 5'd7; IF_ID_RS1 = 5'd1;
    IF_ID_UsesRS2 = 1'b1;
    settle();
    chk_out("lu_rs2", O_STALL);
    tick();
    idle();
    tick();
    ID_EX_MemRead = 1'b1; ID_EX_RD = 5'd7; IF_ID_RS2 = 5'd7; IF_ID_RS1 = 5'd1;
    IF_ID_UsesRS2 = 1'b0;
    settle();
    chk_out("rs2_unused", O_DEF);
    tick();
    idle();
    load_use(5'd0, 5'd0);
    settle();
    chk_out("rd_x0", O_DEF);
    tick();
    idle();

    // branch beats load-use; a fresh lu next cycle still stalls (back in S_RUN)
    load_use(5'd9, 5'd9);
    BRANCH_TAKEN = 1'b1;
    settle();
    chk_out("branch_over_lu", O_BR);
    tick();
    BRANCH_TAKEN = 1'b0;
    settle();
    chk_out("lu_after_branch", O_STALL);
    tick();
    idle();
    tick();

    // 3-cycle freeze with branch held; flush only on release
    DMEM_REQ = 1'b1; DMEM_READY = 1'b0; BRANCH_TAKEN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk_out("freeze_br", O_FRZ);
      tick();
    end
    DMEM_READY = 1'b1;
    settle();
    chk_out("freeze_release_br", O_BR);
    chk_err("freeze3_no_err", 1'b0);
    tick();
    idle();

    // load-use pending during freeze is acted on in the ready cycle
    DMEM_REQ = 1'b1; DMEM_READY = 1'b0;
    load_use(5'd3, 5'd3);
    settle();
    chk_out("freeze_over_lu", O_FRZ);
    tick();
    DMEM_READY = 1'b1;
    settle();
    chk_out("release_lu", O_STALL);
    tick();
    idle();
    tick();

    // timeout: MEM_ERR after the 4th consecutive freeze cycle, sticky
    DMEM_REQ = 1'b1; DMEM_READY = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      settle();
      chk_out("timeout_frz", O_FRZ);
      chk_err("timeout_err", (i > 4) ? 1'b1 : 1'b0);
      tick();
    end
    DMEM_READY = 1'b1;
    settle();
    chk_out("timeout_release", O_DEF);
    chk_err("err_sticky_release", 1'b1);
    tick();
    idle();
    settle();
    chk_err("err_sticky_idle", 1'b1);
    reset = 1'b1;
    settle();
    chk_out("err_reset_flush", O_RST);
    tick();
    reset = 1'b0;
    settle();
    chk_err("err_cleared", 1'b0);
    chk_out("after_reset", O_DEF);
    tick();

    // reset mid-freeze clears the wait counter
    DMEM_REQ = 1'b1; DMEM_READY = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    settle();
    chk_out("reset_over_freeze", O_RST);
    tick();
    reset = 1'b0;
    idle();
    settle();
    chk_out("post_reset_run", O_DEF);
    tick();
    DMEM_REQ = 1'b1; DMEM_READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk_err("wait_cnt_cleared", 1'b0);
      tick();
    end
    DMEM_READY = 1'b1;
    settle();
    chk_err("wait_cnt_cleared_end", 1'b0);
    tick();
    idle();

    // reset mid-stall returns to S_RUN
    load_use(5'd4, 5'd4);
    settle();
    chk_out("stall_before_reset", O_STALL);
    tick();
    reset = 1'b1;
    settle();
    chk_out("reset_over_stall", O_RST);
    tick();
    reset = 1'b0;
    settle();
    chk_out("stall_after_reset", O_STALL);
    tick();
    idle();
    tick();

    // counter workload: 2 bubbles, 3 freeze cycles, 1 branch flush
    reset = 1'b1;
    tick();
    reset = 1'b0;
    load_use(5'd5, 5'd5);
    settle();
    chk_out("perf_lu1", O_STALL);
    tick();
    idle();
    tick();
    load_use(5'd6, 5'd6);
    settle();
    chk_out("perf_lu2", O_STALL);
    tick();
    idle();
    tick();
    DMEM_REQ = 1'b1; DMEM_READY = 1'b0;
    tick();
    tick();
    tick();
    DMEM_READY = 1'b1;
    tick();
    idle();
    BRANCH_TAKEN = 1'b1;
    settle();
    chk_out("perf_branch", O_BR);
    tick();
    idle();
    settle();
`ifdef HAZARD_PERF_CNT_EN
    chk_cnt("stall_cnt", STALL_CNT, 32'd2);
    chk_cnt("freeze_cnt", FREEZE_CNT, 32'd3);
    chk_cnt("flush_cnt", FLUSH_CNT, 32'd1);
`endif
    chk_out("final_default", O_DEF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Stall/flush controller for the 5-stage RV32I pipeline, and the counterpart to the EX-stage operand forwarding logic.
- Forwarding covers every RAW case except load-use. This block detects load-use in ID and inserts exactly one bubble.
- It freezes the whole pipeline while data memory is not ready, and flushes wrong-path instructions on a taken branch/jump resolved in EX.
- Drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB write/flush controls.

Parameters:
- REG_ADDR_W, 5, register index width.
- MEM_TIMEOUT, 64, consecutive not-ready cycles before MEM_ERR is set; legal range 2..65535.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  synchronous, active-high reset.
- IF_ID_RS1  in  REG_ADDR_W  rs1 of the instruction in ID.
- IF_ID_RS2  in  REG_ADDR_W  rs2 of the instruction in ID.
- IF_ID_UsesRS2  in  1  instruction in ID reads rs2 (R/S/B type).
- ID_EX_RD  in  REG_ADDR_W  rd of the instruction in EX.
- ID_EX_MemRead  in  1  instruction in EX is a load.
- BRANCH_TAKEN  in  1  branch/jump in EX redirects the PC.
- DMEM_REQ  in  1  MEM stage holds a load or store.
- DMEM_READY  in  1  data memory completes the access this cycle.
- PCWrite  out  1  PC update enable.
- IF_ID_Write  out  1  IF/ID register enable.
- IF_ID_Flush  out  1  load NOP into IF/ID.
- ID_EX_Write  out  1  ID/EX register enable.
- ID_EX_Flush  out  1  zero ID/EX control bits (bubble).
- EX_MEM_Write  out  1  EX/MEM register enable.
- MEM_WB_Write  out  1  MEM/WB register enable.
- MEM_ERR  out  1  sticky memory-timeout error.

Behaviour:
- Clocking: single clock domain on clk; reset is synchronous and active-high.
- Derived terms:
  - freeze = DMEM_REQ & ~DMEM_READY
  - lu = ID_EX_MemRead & (ID_EX_RD != 0) & (ID_EX_RD == IF_ID_RS1 | (IF_ID_UsesRS2 & ID_EX_RD == IF_ID_RS2))
- FSM states: S_RUN, S_LOAD_STALL, S_MEM_WAIT.
- Outputs are combinational from state and inputs. Default, with no hazard: all *_Write = 1, all *_Flush = 0.
- Priority, highest first: reset > freeze > BRANCH_TAKEN > lu.
- reset asserted:
  - All *_Write = 0; IF_ID_Flush = ID_EX_Flush = 1.
  - MEM_ERR = 0, wait counter = 0, state = S_RUN.
- freeze, any state:
  - All *_Write = 0; no flush.
  - Next state S_MEM_WAIT; wait counter increments, saturating.
  - When the counter reaches MEM_TIMEOUT-1 while freeze is still asserted, MEM_ERR sets and stays set until reset. The freeze continues.
- S_MEM_WAIT with DMEM_READY = 1:
  - Pipeline advances this cycle; counter clears; next state S_RUN.
  - A pending BRANCH_TAKEN or lu is acted on in this same cycle, by the rules below.
- BRANCH_TAKEN, no freeze:
  - IF_ID_Flush = 1, ID_EX_Flush = 1, PCWrite = 1.
  - lu is ignored (wrong path). Next state S_RUN.
  - Latency 0: flush lands on the same clock edge.
- lu in S_RUN or S_MEM_WAIT (ready cycle), no freeze, no branch:
  - PCWrite = 0, IF_ID_Write = 0, ID_EX_Flush = 1. Next state S_LOAD_STALL.
- S_LOAD_STALL:
  - lu is not re-evaluated, so at most one bubble per load.
  - Default outputs; next state S_RUN.
  - If freeze occurs here, freeze rules apply and next state is S_MEM_WAIT.
- rd = x0 never causes a stall.
- Back-to-back loads with dependents each get exactly one bubble.
- Reset mid-freeze or mid-stall returns to S_RUN on the next edge with counters cleared.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - Adds output ports STALL_CNT [CNT_W-1:0], FREEZE_CNT [CNT_W-1:0], FLUSH_CNT [CNT_W-1:0].
  - Each counts cycles in which its condition (lu bubble / freeze / branch flush) is acted on; wraps at 2^CNT_W; cleared by reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package hazard_pkg holds:
  - state encoding: S_RUN = 2'd0, S_LOAD_STALL = 2'd1, S_MEM_WAIT = 2'd2;
  - the REG_ADDR_W default;
  - the x0 index constant.
- One natural sub-module, hazard_perf_counters: the three saturating-free wrap counters, instantiated only under HAZARD_PERF_CNT_EN.
- FSM and output decode stay in the top module.

Test Plan:
- Load-use on rs1:
  - Stimulus: ID_EX_MemRead = 1, ID_EX_RD = 5, IF_ID_RS1 = 5.
  - Required: one cycle of PCWrite = 0, IF_ID_Write = 0, ID_EX_Flush = 1; next cycle defaults even with inputs held.
- rs2 and x0 cases:
  - Stimulus: ID_EX_RD = 7, IF_ID_RS2 = 7.
  - Required: UsesRS2 = 1 stalls; UsesRS2 = 0 does not stall; ID_EX_RD = 0 with RS1 = 0 does not stall.
- Branch beats load-use:
  - Stimulus: BRANCH_TAKEN = 1 together with a lu condition.
  - Required: IF_ID_Flush = 1, ID_EX_Flush = 1, PCWrite = 1; no stall; next state S_RUN.
- Memory freeze:
  - Stimulus: DMEM_REQ = 1, DMEM_READY = 0 for 3 cycles, then 1.
  - Required: all *_Write = 0 for 3 cycles, released on the 4th; BRANCH_TAKEN held during the freeze is flushed only in the release cycle.
- Timeout:
  - Stimulus: MEM_TIMEOUT = 4, freeze held 6 cycles.
  - Required: MEM_ERR rises after the 4th freeze cycle and stays high after DMEM_READY; cleared only by a one-cycle reset, which also forces both flushes = 1.
- Perf counters (HAZARD_PERF_CNT_EN):
  - Stimulus: 2 load-use events, 3 freeze cycles, 1 branch flush.
  - Required: STALL_CNT = 2, FREEZE_CNT = 3, FLUSH_CNT = 1.
